// File: rtl/nios_system_sram_dma_master.sv
// Avalon-MM master on one port of the dual-port on-chip SRAM: block fill,
// block copy and block verify, started by a one-cycle command strobe.
module nios_system_sram_dma_master #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [1:0]          mode,
    input  logic                incr,
    input  logic [ADDR_W-1:0]   src,
    input  logic [ADDR_W-1:0]   dst,
    input  logic [ADDR_W:0]     len,
    input  logic [DATA_W-1:0]   pattern,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W:0]     err_count,
    output logic [ADDR_W-1:0]   err_addr,
    output logic [ADDR_W-1:0]   m_address,
    output logic                m_chipselect,
    output logic                m_write,
    output logic [DATA_W/8-1:0] m_byteenable,
    output logic [DATA_W-1:0]   m_writedata,
    output logic                m_clken,
    input  logic [DATA_W-1:0]   m_readdata
);
    localparam logic [1:0]        MODE_FILL  = 2'd0;
    localparam logic [1:0]        MODE_COPY  = 2'd1;
    localparam logic [1:0]        MODE_CHECK = 2'd2;
    localparam logic [1:0]        MODE_RSVD  = 2'd3;
    localparam logic [ADDR_W:0]   CNT_ONE    = 1;
    localparam logic [ADDR_W-1:0] IDX_ONE    = 1;
    localparam logic [ADDR_W:0]   ERR_MAX    = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [2:0] {IDLE, RD, LAT, WR, DONE} state_t;

    state_t            state, state_next;
    logic [1:0]        mode_r;
    logic              incr_r;
    logic [ADDR_W-1:0] src_r, dst_r;
    logic [DATA_W-1:0] pattern_r;
    logic [ADDR_W-1:0] idx, idx_next;
    logic [ADDR_W:0]   remaining;

    logic              accept, last, word_done, mismatch;
    logic [1:0]        cmd_mode;
    logic              cmd_incr;
    logic [ADDR_W-1:0] cmd_src, cmd_dst;
    logic [DATA_W-1:0] cmd_pattern;
    logic [ADDR_W-1:0] addr_next;
    logic [DATA_W-1:0] wdata_next;
    logic              cs_next, wr_next, busy_next, done_next;

    function automatic logic [DATA_W-1:0] word_data(input logic [DATA_W-1:0] base,
                                                   input logic inc,
                                                   input logic [ADDR_W-1:0] i);
        return inc ? base + DATA_W'(i) : base;
    endfunction

    // In IDLE the first access is set up straight from the command inputs,
    // since the command registers load on that same edge.
    assign cmd_mode    = (state == IDLE) ? mode    : mode_r;
    assign cmd_incr    = (state == IDLE) ? incr    : incr_r;
    assign cmd_src     = (state == IDLE) ? src     : src_r;
    assign cmd_dst     = (state == IDLE) ? dst     : dst_r;
    assign cmd_pattern = (state == IDLE) ? pattern : pattern_r;

    assign accept    = (state == IDLE) && start;
    assign last      = (remaining == CNT_ONE);
    assign word_done = (state == WR) || (state == LAT && mode_r == MODE_CHECK);
    assign mismatch  = (state == LAT) && (mode_r == MODE_CHECK) &&
                       (m_readdata != word_data(pattern_r, incr_r, idx));
    assign idx_next  = accept ? '0 : (word_done ? idx + IDX_ONE : idx);

    assign m_byteenable = '1;
    assign m_clken      = 1'b1;

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) begin
                if (len == '0 || mode == MODE_RSVD) state_next = DONE;
                else if (mode == MODE_FILL)         state_next = WR;
                else                                state_next = RD;
            end
            RD:   state_next = LAT;
            LAT:  if (mode_r == MODE_COPY) state_next = WR;
                  else if (last)           state_next = DONE;
                  else                     state_next = RD;
            WR:   if (last)                    state_next = DONE;
                  else if (mode_r == MODE_FILL) state_next = WR;
                  else                          state_next = RD;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        addr_next  = m_address;
        wdata_next = m_writedata;
        cs_next    = 1'b0;
        wr_next    = 1'b0;
        busy_next  = 1'b0;
        done_next  = 1'b0;
        case (state_next)
            RD: begin
                addr_next = ((cmd_mode == MODE_COPY) ? cmd_src : cmd_dst) + idx_next;
                cs_next   = 1'b1;
                busy_next = 1'b1;
            end
            LAT: busy_next = 1'b1;
            WR: begin
                addr_next  = cmd_dst + idx_next;
                wdata_next = (cmd_mode == MODE_COPY) ? m_readdata
                                                     : word_data(cmd_pattern, cmd_incr, idx_next);
                cs_next    = 1'b1;
                wr_next    = 1'b1;
                busy_next  = 1'b1;
            end
            DONE: done_next = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mode_r    <= mode;
            incr_r    <= incr;
            src_r     <= src;
            dst_r     <= dst;
            pattern_r <= pattern;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            idx          <= '0;
            remaining    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            m_chipselect <= 1'b0;
            m_write      <= 1'b0;
            m_address    <= '0;
            m_writedata  <= '0;
            err_count    <= '0;
            err_addr     <= '0;
        end else begin
            idx          <= idx_next;
            busy         <= busy_next;
            done         <= done_next;
            m_chipselect <= cs_next;
            m_write      <= wr_next;
            m_address    <= addr_next;
            m_writedata  <= wdata_next;
            if (accept)         remaining <= len;
            else if (word_done) remaining <= remaining - CNT_ONE;
            // err_addr latches only while the count is still zero: first miss wins
            if (accept) begin
                err_count <= '0;
                err_addr  <= '0;
            end else if (mismatch) begin
                if (err_count != ERR_MAX) err_count <= err_count + CNT_ONE;
                if (err_count == '0)      err_addr  <= dst_r + idx;
            end
        end
    end
endmodule

// File: tb/tb_nios_system_sram_dma_master.sv
// Bench for nios_system_sram_dma_master: SRAM model plus access/done
// scoreboards filled by each scenario task.
module tb_nios_system_sram_dma_master;
    localparam int AW = 11;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n, start, incr;
    logic [1:0]    mode;
    logic [AW-1:0] src, dst;
    logic [AW:0]   len;
    logic [DW-1:0] pattern;
    logic          busy, done;
    logic [AW:0]   err_count;
    logic [AW-1:0] err_addr, m_address;
    logic          m_chipselect, m_write, m_clken;
    logic [DW/8-1:0] m_byteenable;
    logic [DW-1:0] m_writedata, m_readdata;

    nios_system_sram_dma_master #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .mode(mode), .incr(incr),
        .src(src), .dst(dst), .len(len), .pattern(pattern),
        .busy(busy), .done(done), .err_count(err_count), .err_addr(err_addr),
        .m_address(m_address), .m_chipselect(m_chipselect), .m_write(m_write),
        .m_byteenable(m_byteenable), .m_writedata(m_writedata), .m_clken(m_clken),
        .m_readdata(m_readdata)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    logic [DW-1:0] mem     [0:2**AW-1];
    logic [DW-1:0] ref_mem [0:2**AW-1];
    logic          mem_init = 1'b1;
    logic          bk_we    = 1'b0;
    logic [AW-1:0] bk_addr  = '0;
    logic [DW-1:0] bk_data  = '0;

    function automatic logic [DW-1:0] init_word(input int i);
        return 32'h6B00_0000 + 32'(i) * 32'h0001_0003;
    endfunction

    // SRAM port: one-cycle read latency, plus a back-door write for corruption
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 2**AW; i++) mem[i] <= init_word(i);
        end else begin
            if (bk_we) mem[bk_addr] <= bk_data;
            if (m_chipselect && m_write) mem[m_address] <= m_writedata;
        end
        if (m_chipselect && !m_write) m_readdata <= mem[m_address];
    end

    typedef struct {
        int            cyc;
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } acc_t;

    acc_t acc_q[$];
    int   done_q[$];
    acc_t mon_e;
    int   mon_d;

    always @(negedge clk) begin
        if (m_chipselect === 1'b1) begin
            n_checks++;
            if (acc_q.size() == 0) begin
                $display("FAIL access: unexpected wr=%b addr=%h data=%h at cycle %0d, want no access",
                         m_write, m_address, m_writedata, cyc);
            end else begin
                mon_e = acc_q.pop_front();
                if (mon_e.cyc != cyc || mon_e.wr != m_write || mon_e.addr !== m_address ||
                    (mon_e.wr && mon_e.data !== m_writedata))
                    $display("FAIL access: got cyc=%0d wr=%b addr=%h data=%h, want cyc=%0d wr=%b addr=%h data=%h",
                             cyc, m_write, m_address, m_writedata,
                             mon_e.cyc, mon_e.wr, mon_e.addr, mon_e.data);
                else n_pass++;
            end
        end
        if (done === 1'b1) begin
            n_checks++;
            if (done_q.size() == 0) begin
                $display("FAIL done: unexpected pulse at cycle %0d, want none", cyc);
            end else begin
                mon_d = done_q.pop_front();
                if (mon_d != cyc || busy !== 1'b0)
                    $display("FAIL done: got cycle %0d busy=%b, want cycle %0d busy=0", cyc, busy, mon_d);
                else n_pass++;
            end
        end
    end

    task automatic drive_cmd(input logic [1:0] m, input logic inc, input logic [AW-1:0] s,
                             input logic [AW-1:0] d, input logic [AW:0] l,
                             input logic [DW-1:0] p, output int k);
        @(negedge clk);
        mode = m; incr = inc; src = s; dst = d; len = l; pattern = p; start = 1'b1;
        k = cyc;
    endtask

    task automatic release_cmd();
        @(negedge clk);
        start   = 1'b0;
        mode    = 2'($urandom);
        incr    = 1'($urandom);
        src     = AW'($urandom);
        dst     = AW'($urandom);
        len     = (AW+1)'($urandom);
        pattern = $urandom;
    endtask

    task automatic wait_drain(input int budget);
        for (int t = 0; t < budget; t++) begin
            @(negedge clk); #1;
            if (acc_q.size() == 0 && done_q.size() == 0) break;
        end
    endtask

    task automatic expect_fill(input int k, input logic [AW-1:0] d, input int n,
                               input logic inc, input logic [DW-1:0] p);
        for (int i = 0; i < n; i++) begin
            acc_t e;
            e.cyc = k + 1 + i; e.wr = 1'b1; e.addr = d + AW'(i);
            e.data = inc ? p + DW'(i) : p;
            acc_q.push_back(e);
            ref_mem[e.addr] = e.data;
        end
        done_q.push_back(k + 1 + n);
    endtask

    task automatic expect_copy(input int k, input logic [AW-1:0] s, input logic [AW-1:0] d,
                               input int n);
        for (int i = 0; i < n; i++) begin
            acc_t r, w;
            r.cyc = k + 1 + 3*i; r.wr = 1'b0; r.addr = s + AW'(i); r.data = '0;
            w.cyc = k + 3 + 3*i; w.wr = 1'b1; w.addr = d + AW'(i); w.data = ref_mem[r.addr];
            acc_q.push_back(r);
            acc_q.push_back(w);
            ref_mem[w.addr] = w.data;
        end
        done_q.push_back(k + 1 + 3*n);
    endtask

    task automatic expect_check(input int k, input logic [AW-1:0] d, input int n,
                                input logic inc, input logic [DW-1:0] p,
                                output int errs, output logic [AW-1:0] first);
        errs = 0; first = '0;
        for (int i = 0; i < n; i++) begin
            acc_t r;
            r.cyc = k + 1 + 2*i; r.wr = 1'b0; r.addr = d + AW'(i); r.data = '0;
            acc_q.push_back(r);
            if (ref_mem[r.addr] !== (inc ? p + DW'(i) : p)) begin
                if (errs == 0) first = r.addr;
                errs++;
            end
        end
        done_q.push_back(k + 1 + 2*n);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b1; mode = 2'd0; incr = 1'b1;
        src = '0; dst = '0; len = 12'd4; pattern = 32'hDEAD_0000;
        for (int i = 0; i < 2**AW; i++) ref_mem[i] = init_word(i);
        repeat (3) @(negedge clk);
        mem_init = 1'b0;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
        n_checks++; if (err_count !== '0) $display("FAIL reset_err_count: got %h want 0", err_count); else n_pass++;
        n_checks++; if (err_addr !== '0) $display("FAIL reset_err_addr: got %h want 0", err_addr); else n_pass++;
        n_checks++; if (m_chipselect !== 1'b0) $display("FAIL reset_cs: got %b want 0", m_chipselect); else n_pass++;
        n_checks++; if (m_write !== 1'b0) $display("FAIL reset_write: got %b want 0", m_write); else n_pass++;
        n_checks++; if (m_address !== '0) $display("FAIL reset_address: got %h want 0", m_address); else n_pass++;
        n_checks++; if (m_writedata !== '0) $display("FAIL reset_writedata: got %h want 0", m_writedata); else n_pass++;
        n_checks++; if (m_byteenable !== 4'hF) $display("FAIL reset_byteenable: got %h want f", m_byteenable); else n_pass++;
        n_checks++; if (m_clken !== 1'b1) $display("FAIL reset_clken: got %b want 1", m_clken); else n_pass++;
        start = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_release_busy: got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_fill();
        int k;
        drive_cmd(2'd0, 1'b1, 11'h000, 11'h7FE, 12'd4, 32'hA5A5_0000, k);
        expect_fill(k, 11'h7FE, 4, 1'b1, 32'hA5A5_0000);
        release_cmd();
        wait_drain(40);
        n_checks++; if (acc_q.size() + done_q.size() != 0) $display("FAIL fill_drain: pending %0d want 0", acc_q.size() + done_q.size()); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            logic [AW-1:0] a;
            a = 11'h7FE + AW'(i);
            n_checks++;
            if (mem[a] !== ref_mem[a]) $display("FAIL fill_mem[%h]: got %h want %h", a, mem[a], ref_mem[a]); else n_pass++;
        end
    endtask

    task automatic test_copy();
        int k;
        drive_cmd(2'd1, 1'b0, 11'h010, 11'h100, 12'd3, 32'h0, k);
        expect_copy(k, 11'h010, 11'h100, 3);
        release_cmd();
        wait_drain(40);
        n_checks++; if (acc_q.size() + done_q.size() != 0) $display("FAIL copy_drain: pending %0d want 0", acc_q.size() + done_q.size()); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            logic [AW-1:0] a;
            a = 11'h100 + AW'(i);
            n_checks++;
            if (mem[a] !== ref_mem[a]) $display("FAIL copy_mem[%h]: got %h want %h", a, mem[a], ref_mem[a]); else n_pass++;
        end
    endtask

    task automatic test_check();
        int k, errs;
        logic [AW-1:0] first;
        logic [DW-1:0] p;
        p = 32'h5A5A_C3C3;
        drive_cmd(2'd0, 1'b0, 11'h000, 11'h100, 12'd8, p, k);
        expect_fill(k, 11'h100, 8, 1'b0, p);
        release_cmd();
        wait_drain(40);
        @(negedge clk); bk_we = 1'b1; bk_addr = 11'h102; bk_data = p ^ 32'h0000_0100;
        ref_mem[11'h102] = bk_data;
        @(negedge clk); bk_addr = 11'h105; bk_data = ~p;
        ref_mem[11'h105] = bk_data;
        @(negedge clk); bk_we = 1'b0;
        drive_cmd(2'd2, 1'b0, 11'h000, 11'h100, 12'd8, p, k);
        expect_check(k, 11'h100, 8, 1'b0, p, errs, first);
        release_cmd();
        wait_drain(60);
        n_checks++; if (acc_q.size() + done_q.size() != 0) $display("FAIL check_drain: pending %0d want 0", acc_q.size() + done_q.size()); else n_pass++;
        n_checks++; if (err_count !== (AW+1)'(errs)) $display("FAIL check_err_count: got %0d want %0d", err_count, errs); else n_pass++;
        n_checks++; if (err_addr !== first) $display("FAIL check_err_addr: got %h want %h", err_addr, first); else n_pass++;
        repeat (3) @(negedge clk);
        n_checks++; if (err_count !== (AW+1)'(errs)) $display("FAIL check_hold_count: got %0d want %0d", err_count, errs); else n_pass++;
        n_checks++; if (err_addr !== first) $display("FAIL check_hold_addr: got %h want %h", err_addr, first); else n_pass++;
        // Verify the wrapped incrementing fill: a clean region must clear the old errors
        drive_cmd(2'd2, 1'b1, 11'h000, 11'h7FE, 12'd4, 32'hA5A5_0000, k);
        expect_check(k, 11'h7FE, 4, 1'b1, 32'hA5A5_0000, errs, first);
        release_cmd();
        wait_drain(40);
        n_checks++; if (acc_q.size() + done_q.size() != 0) $display("FAIL check2_drain: pending %0d want 0", acc_q.size() + done_q.size()); else n_pass++;
        n_checks++; if (err_count !== (AW+1)'(errs)) $display("FAIL check2_err_count: got %0d want %0d", err_count, errs); else n_pass++;
        n_checks++; if (err_addr !== first) $display("FAIL check2_err_addr: got %h want %h", err_addr, first); else n_pass++;
    endtask

    task automatic test_len0();
        int k;
        drive_cmd(2'd0, 1'b1, 11'h000, 11'h050, 12'd0, 32'h1234_5678, k);
        done_q.push_back(k + 1);
        release_cmd();
        n_checks++; if (busy !== 1'b0) $display("FAIL len0_busy: got %b want 0", busy); else n_pass++;
        wait_drain(10);
        n_checks++; if (done_q.size() != 0) $display("FAIL len0_done: pending %0d want 0", done_q.size()); else n_pass++;
        drive_cmd(2'd3, 1'b0, 11'h020, 11'h060, 12'd5, 32'h8765_4321, k);
        done_q.push_back(k + 1);
        release_cmd();
        n_checks++; if (busy !== 1'b0) $display("FAIL mode3_busy: got %b want 0", busy); else n_pass++;
        wait_drain(10);
        repeat (2) @(negedge clk);
        n_checks++; if (done_q.size() != 0) $display("FAIL mode3_done: pending %0d want 0", done_q.size()); else n_pass++;
    endtask

    task automatic test_busy_start();
        int k;
        drive_cmd(2'd0, 1'b1, 11'h000, 11'h300, 12'd4, 32'h1111_0000, k);
        expect_fill(k, 11'h300, 4, 1'b1, 32'h1111_0000);
        release_cmd();
        @(negedge clk);
        mode = 2'd2; len = 12'd5; dst = 11'h400; start = 1'b1;
        repeat (4) @(negedge clk);
        start = 1'b0;
        wait_drain(40);
        repeat (3) @(negedge clk);
        n_checks++; if (acc_q.size() + done_q.size() != 0) $display("FAIL busy_start_drain: pending %0d want 0", acc_q.size() + done_q.size()); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL busy_start_idle: got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_abort();
        int k;
        acc_t e;
        drive_cmd(2'd1, 1'b0, 11'h010, 11'h200, 12'd3, 32'h0, k);
        for (int i = 0; i < 2; i++) begin
            e.cyc = k + 1 + 3*i; e.wr = 1'b0; e.addr = 11'h010 + AW'(i); e.data = '0;
            acc_q.push_back(e);
            e.cyc = k + 3 + 3*i; e.wr = 1'b1; e.addr = 11'h200 + AW'(i); e.data = ref_mem[11'h010 + AW'(i)];
            acc_q.push_back(e);
            ref_mem[e.addr] = e.data;
        end
        release_cmd();
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (m_chipselect !== 1'b0) $display("FAIL abort_cs: got %b want 0", m_chipselect); else n_pass++;
        n_checks++; if (m_address !== '0) $display("FAIL abort_address: got %h want 0", m_address); else n_pass++;
        n_checks++; if (m_writedata !== '0) $display("FAIL abort_writedata: got %h want 0", m_writedata); else n_pass++;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        n_checks++; if (acc_q.size() != 0) $display("FAIL abort_pending: got %0d want 0", acc_q.size()); else n_pass++;
        n_checks++; if (mem[11'h201] !== ref_mem[11'h201]) $display("FAIL abort_mem: got %h want %h", mem[11'h201], ref_mem[11'h201]); else n_pass++;
        n_checks++; if (mem[11'h202] !== init_word(11'h202)) $display("FAIL abort_mem_untouched: got %h want %h", mem[11'h202], init_word(11'h202)); else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fill();
        test_copy();
        test_check();
        test_len0();
        test_busy_start();
        test_abort();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
